// File: rtl/quad_pkg.sv
// Shared types and helpers for the quadrature up/down decoder.
// Phase encodings, direction constants and the transition classifier.
// Optional glitch filter is enabled with QUAD_GLITCH_FILTER_EN.
package quad_pkg;

    // 2-bit phase state {A,B} in up-count order 00 -> 10 -> 11 -> 01 -> 00
    typedef enum logic [1:0] {
        PH_00 = 2'b00,
        PH_10 = 2'b10,
        PH_11 = 2'b11,
        PH_01 = 2'b01
    } phase_t;

    localparam logic DIR_UP = 1'b0;
    localparam logic DIR_DN = 1'b1;

    // Glitch filter: value must differ from the filtered output on this many
    // consecutive clocks beyond the first before it is accepted (4 clocks total).
    localparam logic [2:0] FILT_LAST = 3'd3;

    // Result of classifying one prev -> cur phase transition
    typedef struct packed {
        logic count;    // legal transition that counts at this resolution
        logic dir;      // DIR_UP / DIR_DN, meaningful when count=1
        logic illegal;  // both phase bits changed in one sample
    } trans_t;

    // Classify a transition for resolution res (1, 2 or 4 counts per cycle)
    function automatic trans_t classify(input logic [1:0] prev,
                                        input logic [1:0] cur,
                                        input int         res);
        trans_t t;
        logic   up;
        logic   dn;
        logic   hit;
        t   = '0;
        // next state in the up direction is {~B, A}; down is {B, ~A}
        up  = (cur == {~prev[0], prev[1]});
        dn  = (cur == {prev[0], ~prev[1]});
        case (res)
            1:       hit = (cur == PH_00);
            2:       hit = (cur == PH_00) || (cur == PH_11);
            default: hit = 1'b1;
        endcase
        t.illegal = ((prev ^ cur) == 2'b11);
        t.count   = (up | dn) & hit;
        t.dir     = dn ? DIR_DN : DIR_UP;
        return t;
    endfunction

endpackage

// File: rtl/quad_sync_filt.sv
// Per-phase synchronizer with optional glitch filter (QUAD_GLITCH_FILTER_EN).
// Latency SYNC_STAGES clocks, plus 4 clocks when the filter is built in.
// No backpressure: free-running sampler of an asynchronous pin.
module quad_sync_filt
    import quad_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic CLK,
    input  logic CDN,
    input  logic pin,
    output logic ph_s
);

    logic [SYNC_STAGES-1:0] sync;

    // Metastability chain; bit 0 captures the raw pin
    always_ff @(posedge CLK or negedge CDN) begin
        if (!CDN) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], pin};
        end
    end

`ifdef QUAD_GLITCH_FILTER_EN
    logic [2:0] stable_cnt;
    logic       filt;

    // Accept a new level only after it has differed from the output for 4 clocks
    always_ff @(posedge CLK or negedge CDN) begin
        if (!CDN) begin
            stable_cnt <= '0;
            filt       <= 1'b0;
        end else if (sync[SYNC_STAGES-1] == filt) begin
            stable_cnt <= '0;
        end else if (stable_cnt == FILT_LAST) begin
            stable_cnt <= '0;
            filt       <= sync[SYNC_STAGES-1];
        end else begin
            stable_cnt <= stable_cnt + 3'd1;
        end
    end

    assign ph_s = filt;
`else
    assign ph_s = sync[SYNC_STAGES-1];
`endif

endmodule

// File: rtl/quad_updn_decoder.sv
// Quadrature A/B decoder: count strobe + direction for counter macros, internal position count.
// Latency A/B edge -> EN_OUT is SYNC_STAGES+1 clocks (SYNC_STAGES+5 with QUAD_GLITCH_FILTER_EN).
// No backpressure: strobes are single-cycle and cannot be stalled; EN=0 only suppresses them.
module quad_updn_decoder
    import quad_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int RES         = 4
) (
    input  logic             CLK,
    input  logic             CDN,
    input  logic             A,
    input  logic             B,
    input  logic             EN,
    input  logic             CS,
    output logic             EN_OUT,
    output logic             DNUP_OUT,
    output logic             CAI_OUT,
    output logic [WIDTH-1:0] Q,
    output logic             CAO,
    output logic             ERR
);

    // Clocks after CDN release until the synchronized phases carry real pin
    // values; the synchronizer (and filter) reset to 0, so loading the tracked
    // phase any earlier would turn a pin level of 11 into a false 00->11 event.
`ifdef QUAD_GLITCH_FILTER_EN
    localparam int PRIME_CLKS = SYNC_STAGES + 5;
`else
    localparam int PRIME_CLKS = SYNC_STAGES + 1;
`endif
    localparam logic [3:0]       PRIME_LAST = 4'(PRIME_CLKS - 1);
    localparam logic [WIDTH-1:0] Q_ONE      = WIDTH'(1);

    logic             a_s;
    logic             b_s;
    logic [1:0]       cur;
    logic [1:0]       prev;
    logic             init;
    logic [3:0]       fill_cnt;
    trans_t           trans;
    logic             strobe;
    logic             en_out;
    logic             dnup;
    logic [WIDTH-1:0] q_cnt;
    logic             err;

    quad_sync_filt #(.SYNC_STAGES(SYNC_STAGES)) u_sync_a (
        .CLK  (CLK),
        .CDN  (CDN),
        .pin  (A),
        .ph_s (a_s)
    );

    quad_sync_filt #(.SYNC_STAGES(SYNC_STAGES)) u_sync_b (
        .CLK  (CLK),
        .CDN  (CDN),
        .pin  (B),
        .ph_s (b_s)
    );

    assign cur    = {a_s, b_s};
    assign trans  = classify(prev, cur, RES);
    assign strobe = trans.count & EN & ~init;

    // Phase tracking: hold off until the sync pipeline is primed, then follow S every clock
    always_ff @(posedge CLK or negedge CDN) begin
        if (!CDN) begin
            init     <= 1'b1;
            fill_cnt <= '0;
            prev     <= PH_00;
        end else if (init) begin
            if (fill_cnt == PRIME_LAST) begin
                prev <= cur;
                init <= 1'b0;
            end else begin
                fill_cnt <= fill_cnt + 4'd1;
            end
        end else begin
            prev <= cur;
        end
    end

    // Registered strobe/direction, sticky error and position count; CS overrides everything
    always_ff @(posedge CLK or negedge CDN) begin
        if (!CDN) begin
            en_out <= 1'b0;
            dnup   <= DIR_UP;
            q_cnt  <= '0;
            err    <= 1'b0;
        end else if (CS) begin
            en_out <= 1'b0;
            q_cnt  <= '0;
            err    <= 1'b0;
        end else begin
            en_out <= strobe;
            if (strobe) begin
                dnup <= trans.dir;
            end
            if (trans.illegal && !init) begin
                err <= 1'b1;
            end
            // Q follows the strobe one clock later so CAO sees the pre-update count
            if (en_out) begin
                q_cnt <= (dnup == DIR_DN) ? (q_cnt - Q_ONE) : (q_cnt + Q_ONE);
            end
        end
    end

    assign EN_OUT   = en_out;
    assign CAI_OUT  = en_out;
    assign DNUP_OUT = dnup;
    assign Q        = q_cnt;
    assign ERR      = err;
    assign CAO      = en_out & ((dnup & ~|q_cnt) | (~dnup & (&q_cnt)));

endmodule

// File: tb/tb_quad_updn_decoder.sv
module tb_quad_updn_decoder;

    localparam int SYNC = 2;
`ifdef QUAD_GLITCH_FILTER_EN
    localparam int LAT = SYNC + 5;
`else
    localparam int LAT = SYNC + 1;
`endif

    logic       CLK = 1'b0;
    logic       CDN;
    logic       A, B, EN, CS;
    logic       A1, B1, EN1, CS1;
    logic       EN_OUT, DNUP_OUT, CAI_OUT, CAO, ERR;
    logic [7:0] Q;
    logic       EN_OUT1, DNUP_OUT1, CAI_OUT1, CAO1, ERR1;
    logic [7:0] Q1;

    int n_chk  = 0;
    int n_fail = 0;
    int pulses = 0, ups = 0, dns = 0, caos = 0;
    logic last_dn = 1'b0, last_cao = 1'b0;
    int first_lat = -1;
    int p1 = 0, p1_on00 = 0, d1 = 0;
    int cai_bad = 0;
    int base;

    always #5 CLK = ~CLK;

    quad_updn_decoder #(.WIDTH(8), .SYNC_STAGES(SYNC), .RES(4)) dut (
        .CLK(CLK), .CDN(CDN), .A(A), .B(B), .EN(EN), .CS(CS),
        .EN_OUT(EN_OUT), .DNUP_OUT(DNUP_OUT), .CAI_OUT(CAI_OUT),
        .Q(Q), .CAO(CAO), .ERR(ERR)
    );

    quad_updn_decoder #(.WIDTH(8), .SYNC_STAGES(SYNC), .RES(1)) dut1 (
        .CLK(CLK), .CDN(CDN), .A(A1), .B(B1), .EN(EN1), .CS(CS1),
        .EN_OUT(EN_OUT1), .DNUP_OUT(DNUP_OUT1), .CAI_OUT(CAI_OUT1),
        .Q(Q1), .CAO(CAO1), .ERR(ERR1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock; outputs sampled at the falling edge
    task automatic tick();
        @(negedge CLK);
        if (CAI_OUT !== EN_OUT || CAI_OUT1 !== EN_OUT1) cai_bad++;
        if (EN_OUT === 1'b1) begin
            pulses++;
            if (DNUP_OUT) dns++; else ups++;
            if (CAO) caos++;
            last_dn  = DNUP_OUT;
            last_cao = CAO;
        end
        if (EN_OUT1 === 1'b1) begin
            p1++;
            if (DNUP_OUT1) d1++;
            if (A1 == 1'b0 && B1 == 1'b0) p1_on00++;
        end
    endtask

    task automatic step(input logic a, input logic b, input int n);
        A = a; B = b;
        for (int i = 1; i <= n; i++) begin
            tick();
            if (EN_OUT === 1'b1 && first_lat < 0) first_lat = i;
        end
    endtask

    task automatic step1(input logic a, input logic b, input int n);
        A1 = a; B1 = b;
        for (int i = 1; i <= n; i++) tick();
    endtask

    task automatic cs_pulse();
        CS = 1'b1; tick(); CS = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with inputs at 11
        CDN = 1'b0; A = 1'b1; B = 1'b1; EN = 1'b1; CS = 1'b0;
        A1 = 1'b1; B1 = 1'b1; EN1 = 1'b1; CS1 = 1'b0;
        tick(); tick(); tick();
        chk("rst_q", Q, 0);
        chk("rst_en_out", EN_OUT, 0);
        chk("rst_dnup", DNUP_OUT, 0);
        chk("rst_err", ERR, 0);
        CDN = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        chk("hold11_pulses", pulses, 0);
        chk("hold11_err", ERR, 0);
        chk("hold11_q", Q, 0);
        chk("hold11_err1", ERR1, 0);
        chk("hold11_p1", p1, 0);

        // Move 11 -> 01 -> 00 (two up counts), then clear
        step(0, 1, 8);
        step(0, 0, 8);
        chk("pre_q", Q, 2);
        chk("pre_ups", ups, 2);
        cs_pulse();
        chk("cs_q", Q, 0);

        // RES=4 up sequence x3
        pulses = 0; ups = 0; dns = 0; caos = 0; first_lat = -1;
        for (int r = 0; r < 3; r++) begin
            step(1, 0, 8);
            step(1, 1, 8);
            step(0, 1, 8);
            step(0, 0, 8);
        end
        chk("up_pulses", pulses, 12);
        chk("up_dns", dns, 0);
        chk("up_q", Q, 12);
        chk("up_latency", first_lat, LAT);
        chk("up_no_cao", caos, 0);

        // Wrap down from 0 and back up
        cs_pulse();
        pulses = 0; caos = 0;
        step(0, 1, 8);
        chk("dn_pulses", pulses, 1);
        chk("dn_dir", last_dn, 1);
        chk("dn_cao", last_cao, 1);
        chk("dn_q_wrap", Q, 255);
        chk("dn_dir_hold", DNUP_OUT, 1);
        step(0, 0, 8);
        chk("wrap_up_pulses", pulses, 2);
        chk("wrap_up_dir", last_dn, 0);
        chk("wrap_up_cao", last_cao, 1);
        chk("wrap_up_q", Q, 0);

        // Illegal 00 -> 11
        pulses = 0;
        step(1, 1, 8);
        chk("ill_err", ERR, 1);
        chk("ill_pulses", pulses, 0);
        chk("ill_q", Q, 0);
        step(0, 1, 8);
        step(0, 0, 8);
        chk("ill_after_pulses", pulses, 2);
        chk("ill_after_q", Q, 2);
        chk("ill_err_sticky", ERR, 1);
        cs_pulse();
        chk("ill_cs_err", ERR, 0);
        chk("ill_cs_q", Q, 0);

        // RES=1 instance: two full up cycles from 11
        for (int r = 0; r < 2; r++) begin
            step1(0, 1, 8);
            step1(0, 0, 8);
            step1(1, 0, 8);
            step1(1, 1, 8);
        end
        chk("r1_pulses", p1, 2);
        chk("r1_on00", p1_on00, 2);
        chk("r1_dns", d1, 0);
        chk("r1_q", Q1, 2);
        EN1 = 1'b0;
        step1(0, 1, 8);
        step1(0, 0, 8);
        step1(1, 0, 8);
        step1(1, 1, 8);
        chk("r1_en0_pulses", p1, 2);
        chk("r1_en0_q", Q1, 2);
        EN1 = 1'b1;
        step1(0, 1, 8);
        step1(0, 0, 8);
        chk("r1_resume_pulses", p1, 3);
        chk("r1_resume_q", Q1, 3);
        step1(1, 0, 8);
        step1(0, 0, 8);
        chk("r1_down_pulses", p1, 4);
        chk("r1_down_dns", d1, 1);
        chk("r1_down_q", Q1, 2);

`ifdef QUAD_GLITCH_FILTER_EN
        // Short pulse on A is rejected; a stable step counts at filtered latency
        base = pulses;
        A = 1'b1; tick(); tick();
        A = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        chk("glitch_pulses", pulses - base, 0);
        chk("glitch_err", ERR, 0);
        first_lat = -1;
        step(1, 0, 8);
        chk("filt_pulses", pulses - base, 1);
        chk("filt_latency", first_lat, SYNC + 5);
        chk("filt_q", Q, 1);
`endif

        // Mid-operation reset
        base = pulses;
        step(~B, A, 8);
        chk("pre_rst_step", pulses - base, 1);
        step(~A, ~B, 8);
        chk("pre_rst_err", ERR, 1);
        CDN = 1'b0;
        #1;
        chk("async_rst_q", Q, 0);
        chk("async_rst_err", ERR, 0);
        chk("async_rst_q1", Q1, 0);
        tick();
        CDN = 1'b1;
        base = pulses;
        for (int i = 0; i < 20; i++) tick();
        chk("rerst_pulses", pulses - base, 0);
        chk("rerst_err", ERR, 0);
        chk("cai_tracks_en", cai_bad, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
